// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment display scheduler.
// Latency: none (declarations only). Backpressure: not applicable.
package seg7_pkg;

    localparam int SEG7_DATA_W     = 8;
    localparam int SEG7_BCD_DIGITS = 3;

    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_ADJ    = 4'd3;

    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;
    typedef enum logic {REQ_A, REQ_B} req_t;

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble adjust: digits of 5 or more get 3 added before the shift.
// Latency: purely combinational. Backpressure: none.
module bcd_add3
    import seg7_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= ADD3_THRESH) ? d + ADD3_ADJ : d;

endmodule

// File: rtl/seg7_display_scheduler.sv
// Round-robin share of the BCD display field between requesters A and B, binary->BCD by double-dabble.
// Latency: handshake edge T -> bcd/bcd_update in cycle T+DATA_W, then held HOLD_CYCLES cycles.
// Backpressure: ready only in IDLE; LEADING_ZERO_BLANK_EN enables the leading-zero blank mask.
module seg7_display_scheduler
    import seg7_pkg::*;
#(
    parameter int DATA_W      = SEG7_DATA_W,
    parameter int BCD_DIGITS  = SEG7_BCD_DIGITS,
    parameter int HOLD_CYCLES = 50_000
) (
    input  logic                    clk_50MHz,
    input  logic                    reset_n,
    input  logic                    a_valid,
    input  logic [DATA_W-1:0]       a_data,
    output logic                    a_ready,
    input  logic                    b_valid,
    input  logic [DATA_W-1:0]       b_data,
    output logic                    b_ready,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    bcd_update,
    output logic                    busy,
    output logic [BCD_DIGITS-1:0]   blank
);

    localparam int BCD_W  = 4 * BCD_DIGITS;
    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

    generate
        if (2.0 ** DATA_W > 10.0 ** BCD_DIGITS) begin : g_width_check
            $error("seg7_display_scheduler: 2**DATA_W-1 does not fit in BCD_DIGITS digits");
        end
    endgenerate

    state_t                  state_q, state_d;
    req_t                    last_q, last_d;
    logic [DATA_W-1:0]       bin_q, bin_d;
    logic [BCD_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic                    upd_q, upd_d;
    logic [BCD_DIGITS-1:0]   blank_q, blank_d;

    logic [BCD_W-1:0]        adj;
    logic [BCD_W+DATA_W-1:0] shift_w;
    logic [BCD_W-1:0]        acc_shift;
    logic [DATA_W-1:0]       bin_shift;
    logic [BCD_DIGITS-1:0]   blank_calc;
    logic                    a_rdy, b_rdy;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d (acc_q[4*g +: 4]),
            .q (adj[4*g +: 4])
        );
    end

    assign shift_w   = {adj, bin_q} << 1;
    assign acc_shift = shift_w[BCD_W+DATA_W-1 -: BCD_W];
    assign bin_shift = shift_w[DATA_W-1:0];

`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    // A digit blanks only while every digit above it is also zero.
    always_comb begin
        blank_calc = '0;
        lead       = 1'b1;
        for (int i = BCD_DIGITS - 1; i > 0; i--) begin
            lead          = lead && (acc_shift[4*i +: 4] == 4'd0);
            blank_calc[i] = lead;
        end
    end
`else
    assign blank_calc = '0;
`endif

    // The requester that did not win last time has priority on a tie.
    always_comb begin
        a_rdy = 1'b0;
        b_rdy = 1'b0;
        if (reset_n && state_q == IDLE) begin
            if (a_valid && (!b_valid || last_q == REQ_B)) begin
                a_rdy = 1'b1;
            end else if (b_valid) begin
                b_rdy = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        bcd_d   = bcd_q;
        upd_d   = 1'b0;
        blank_d = blank_q;
        case (state_q)
            IDLE: begin
                if (a_rdy || b_rdy) begin
                    bin_d   = a_rdy ? a_data : b_data;
                    last_d  = a_rdy ? REQ_A : REQ_B;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                bin_d = bin_shift;
                acc_d = acc_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    bcd_d   = acc_shift;
                    blank_d = blank_calc;
                    upd_d   = 1'b1;
                    hold_d  = '0;
                    state_d = (HOLD_CYCLES == 0) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HOLD_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= REQ_B;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            bcd_q   <= '0;
            upd_q   <= 1'b0;
            blank_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            bcd_q   <= bcd_d;
            upd_q   <= upd_d;
            blank_q <= blank_d;
        end
    end

    assign a_ready    = a_rdy;
    assign b_ready    = b_rdy;
    assign bcd        = bcd_q;
    assign bcd_update = upd_q;
    assign busy       = (state_q == CONV) || (state_q == HOLD);
    assign blank      = blank_q;

endmodule

// File: tb/tb_seg7_display_scheduler.sv
// Bench for seg7_display_scheduler: transaction-level model checked every cycle plus directed literals.
module tb_seg7_display_scheduler;

    localparam int DW = 8;
    localparam int ND = 3;
    localparam int HC = 4;

    logic          clk_50MHz = 1'b0;
    logic          reset_n   = 1'b1;
    logic          a_valid   = 1'b0;
    logic [DW-1:0] a_data    = '0;
    logic          b_valid   = 1'b0;
    logic [DW-1:0] b_data    = '0;
    logic          a_ready, b_ready, bcd_update, busy;
    logic [4*ND-1:0] bcd;
    logic [ND-1:0]   blank;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_50MHz = ~clk_50MHz;

    seg7_display_scheduler #(
        .DATA_W      (DW),
        .BCD_DIGITS  (ND),
        .HOLD_CYCLES (HC)
    ) dut (
        .clk_50MHz  (clk_50MHz),
        .reset_n    (reset_n),
        .a_valid    (a_valid),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .bcd        (bcd),
        .bcd_update (bcd_update),
        .busy       (busy),
        .blank      (blank)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    int          m_busy  = 0;      // cycles left before the scheduler accepts again
    int          m_conv  = 0;      // cycles left until the result appears
    bit          m_last  = 1'b1;   // 1: B was granted last
    logic [7:0]  m_val   = '0;
    logic [11:0] m_bcd   = '0;
    bit          m_upd   = 1'b0;
    logic [2:0]  m_blank = '0;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [2:0] blank_of(input int v);
`ifdef LEADING_ZERO_BLANK_EN
        return {v < 100, v < 10, 1'b0};
`else
        return 3'b000;
`endif
    endfunction

    function automatic logic [2:0] bl(input logic [2:0] x);
`ifdef LEADING_ZERO_BLANK_EN
        return x;
`else
        return 3'b000;
`endif
    endfunction

    function automatic bit exp_a();
        return reset_n && m_busy == 0 && a_valid && (!b_valid || m_last);
    endfunction

    function automatic bit exp_b();
        return reset_n && m_busy == 0 && b_valid && (!a_valid || !m_last);
    endfunction

    always @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_conv = 0; m_last = 1'b1;
            m_bcd = '0; m_upd = 1'b0; m_blank = '0;
        end else begin
            m_upd = 1'b0;
            if (m_busy == 0) begin
                if (exp_a()) begin
                    m_val = a_data; m_last = 1'b0; m_busy = DW + HC; m_conv = DW;
                end else if (exp_b()) begin
                    m_val = b_data; m_last = 1'b1; m_busy = DW + HC; m_conv = DW;
                end
            end else begin
                m_busy--;
                if (m_conv > 0) begin
                    m_conv--;
                    if (m_conv == 0) begin
                        m_bcd = to_bcd(m_val); m_blank = blank_of(m_val); m_upd = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk_50MHz) begin
        chk("a_ready",    a_ready,    exp_a());
        chk("b_ready",    b_ready,    exp_b());
        chk("bcd",        bcd,        m_bcd);
        chk("bcd_update", bcd_update, m_upd);
        chk("busy",       busy,       m_busy > 0);
        chk("blank",      blank,      m_blank);
    end

    // ---------------- directed stimulus ----------------
    task automatic convert(input bit sel_b, input logic [7:0] v, input logic [11:0] exp_bcd,
                           input logic [2:0] exp_blank, input int mid, input string nm);
        bit got;
        int lat, pulses;
        @(posedge clk_50MHz); #2;
        if (sel_b) begin b_valid = 1'b1; b_data = v; end
        else begin a_valid = 1'b1; a_data = v; end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_50MHz);
            got = sel_b ? b_ready : a_ready;
        end
        chk({nm, "_grant"}, got, 1);
        if (!got) return;
        @(posedge clk_50MHz); #2;
        a_valid = 1'b0; b_valid = 1'b0;
        lat = -1; pulses = 0;
        for (int i = 0; i < DW + HC + 3; i++) begin
            @(negedge clk_50MHz);
            if (i == 0) chk({nm, "_busy"}, busy, 1);
            if (i == mid) begin a_data = 8'd77; b_data = 8'd77; end
            if (bcd_update) begin
                pulses++;
                if (lat < 0) lat = i;
            end
        end
        chk({nm, "_latency"}, lat, DW);
        chk({nm, "_pulses"}, pulses, 1);
        chk({nm, "_bcd"}, bcd, exp_bcd);
        chk({nm, "_blank"}, blank, exp_blank);
    endtask

    bit          who;
    bit          got;
    bit          exp_who [3] = '{1'b0, 1'b1, 1'b0};
    logic [11:0] exp_seq [3] = '{12'h042, 12'h255, 12'h042};

    initial begin
        #1 reset_n = 1'b0;
        a_valid = 1'b1;
        repeat (2) @(posedge clk_50MHz);
        @(negedge clk_50MHz);
        chk("rst_bcd", bcd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_update", bcd_update, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_blank", blank, 0);
        @(posedge clk_50MHz); #2;
        a_valid = 1'b0;
        reset_n = 1'b1;

        convert(1'b0, 8'd173, 12'h173, bl(3'b000), -1, "d173");
        convert(1'b0, 8'd0,   12'h000, bl(3'b110), -1, "d0");
        convert(1'b1, 8'd9,   12'h009, bl(3'b110), -1, "d9");
        convert(1'b0, 8'd99,  12'h099, bl(3'b100), -1, "d99");
        convert(1'b1, 8'd100, 12'h100, bl(3'b000), -1, "d100");
        convert(1'b0, 8'd255, 12'h255, bl(3'b000), -1, "d255");
        convert(1'b0, 8'd50,  12'h050, bl(3'b100), 3,  "mid_data");

        // reset asserted during iteration 4 of a conversion of 200
        @(posedge clk_50MHz); #2;
        a_valid = 1'b1; a_data = 8'd200;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_50MHz);
            got = a_ready;
        end
        chk("rstmid_grant", got, 1);
        @(posedge clk_50MHz); #2;
        a_valid = 1'b0;
        repeat (5) @(negedge clk_50MHz);
        #2 reset_n = 1'b0;
        a_valid = 1'b1;
        #1;
        chk("rstmid_bcd", bcd, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_a_ready", a_ready, 0);
        chk("rstmid_b_ready", b_ready, 0);
        chk("rstmid_update", bcd_update, 0);
        repeat (2) @(posedge clk_50MHz);
        #2 reset_n = 1'b1;
        a_valid = 1'b0;
        convert(1'b0, 8'd200, 12'h200, bl(3'b000), -1, "d200");

        convert(1'b0, 8'd7,   12'h007, bl(3'b110), -1, "blank7");
        convert(1'b1, 8'd0,   12'h000, bl(3'b110), -1, "blank0");
        convert(1'b0, 8'd40,  12'h040, bl(3'b100), -1, "blank40");
        convert(1'b1, 8'd120, 12'h120, bl(3'b000), -1, "blank120");

        // both requesters held valid from reset: grants must alternate A, B, A
        @(posedge clk_50MHz); #2 reset_n = 1'b0;
        @(posedge clk_50MHz); #2 reset_n = 1'b1;
        a_valid = 1'b1; a_data = 8'd42;
        b_valid = 1'b1; b_data = 8'd255;
        for (int g = 0; g < 3; g++) begin
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk_50MHz);
                if (a_ready || b_ready) begin got = 1'b1; who = b_ready; end
            end
            chk("arb_grant", got, 1);
            chk("arb_who", who, exp_who[g]);
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk_50MHz);
                got = bcd_update;
            end
            chk("arb_update", got, 1);
            chk("arb_bcd", bcd, exp_seq[g]);
        end
        @(posedge clk_50MHz); #2;
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (DW + HC + 2) @(posedge clk_50MHz);

        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg7_display_scheduler.md
Name: seg7_display_scheduler

Overview:
Shares the 3-digit numeric field of the 4-digit 7-segment display between two binary requesters (A: live counter value, B: user-loaded value) using round-robin arbitration. Converts the granted 8-bit binary word to packed BCD with a sequential shift-add-3 (double-dabble) engine. Holds each result for a minimum dwell time before accepting the next request. Drives the bcd[11:0] input of the segment/digit multiplexer.

Parameters:
DATA_W, 8, binary input width; must satisfy 2^DATA_W-1 < 10^BCD_DIGITS, otherwise elaboration error
BCD_DIGITS, 3, BCD digits produced; bcd width = 4*BCD_DIGITS
HOLD_CYCLES, 50_000, minimum clk_50MHz cycles a result is held before the next grant (1 ms); 0 is legal

Ports:
clk_50MHz  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous, active-low reset
a_valid  in  1  requester A has data
a_data  in  DATA_W  requester A value
a_ready  out  1  A handshake accepted this cycle
b_valid  in  1  requester B has data
b_data  in  DATA_W  requester B value
b_ready  out  1  B handshake accepted this cycle
bcd  out  4*BCD_DIGITS  packed BCD to display driver, ones digit in [3:0]
bcd_update  out  1  one-cycle pulse when bcd changes
busy  out  1  high in CONV and HOLD
blank  out  BCD_DIGITS  leading-zero blank mask (see Optional Feature)

Behaviour:
- Reset (async, reset_n low): state=IDLE; bcd=0; bcd_update=0; a_ready=b_ready=0; busy=0; blank=0; last_grant=B, so A wins the first tie.
- States: IDLE, CONV, HOLD.
- IDLE arbitration: ready is combinational from state and valids.
  - Only A valid -> a_ready=1.
  - Only B valid -> b_ready=1.
  - Both valid -> grant the requester that is not last_grant.
  - At most one ready is high at a time. Ready is never high outside IDLE.
- Handshake: valid&&ready at a rising edge.
  - The winner's data is latched into the shift register and last_grant is updated.
  - Digit accumulator is cleared and the state moves to CONV.
  - Valid may drop without a handshake; there is no obligation to hold it.
- CONV: iteration counter runs 0..DATA_W-1, one iteration per cycle.
  - For each digit >=5, add 3.
  - Then shift {digits, binary} left by 1.
  - Inputs are ignored during CONV.
- Completion, on the edge ending iteration DATA_W-1:
  - bcd is loaded with the digit accumulator.
  - bcd_update is high for exactly the following cycle.
  - State goes to HOLD, or to IDLE if HOLD_CYCLES==0.
- Latency: handshake at edge T -> bcd valid and bcd_update high in cycle T+DATA_W (8 cycles).
- HOLD: counts HOLD_CYCLES cycles, then IDLE. The next handshake is possible in the first IDLE cycle. The hold counter is sized to clog2(HOLD_CYCLES+1).
- bcd holds its value in every state except at completion. There is no intermediate value on bcd.
- Digits never exceed 9. All values 0..2^DATA_W-1 convert exactly.
- Reset mid-CONV or mid-HOLD: immediate return to reset values. The partial result is discarded and the next conversion after release is unaffected.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: at completion, blank[i]=1 for every digit i>0 that is zero and has only zero digits above it. blank[0] is always 0. blank updates together with bcd.
- Undefined: blank is tied to 0. The port is always present.

Decomposition:
- Package seg7_pkg:
  - state enum {IDLE, CONV, HOLD}
  - DATA_W and BCD_DIGITS defaults
  - digit add-3 threshold constant (5) and adjust (3)
  - requester-id enum {REQ_A, REQ_B}
- Sub-module bcd_add3: purely combinational 4-bit adjust (d>=5 ? d+3 : d), instantiated BCD_DIGITS times in the shift datapath. All state stays in the top module.

Test Plan:
- Reset then A valid 8'd173, B idle -> a_ready high in the first IDLE cycle; 8 cycles later bcd=12'h173 with a single bcd_update pulse; busy high through CONV/HOLD.
- Boundaries with HOLD_CYCLES=4 -> 0->12'h000, 9->12'h009, 99->12'h099, 100->12'h100, 255->12'h255; each followed by exactly one update pulse.
- A=42 and B=255 both held valid from reset -> grants alternate A, B, A; bcd sequence 042, 255, 042; ready never high in CONV/HOLD; b_ready rises in the first cycle after 4 HOLD cycles.
- a_data changed mid-CONV from 50 to 77 -> result remains 12'h050.
- reset_n low during iteration 4 of converting 200 -> bcd=0, busy=0, readys low immediately; after release, A=200 yields 12'h200 with normal latency.
- With LEADING_ZERO_BLANK_EN -> 7 gives blank=3'b110; 0 gives 3'b110; 40 gives 3'b100; 120 gives 3'b000. Without the macro, blank stays 3'b000.
